// File: rtl/alu_sched_if.sv
// Handshake bundle between the two requesters and the shared-ALU scheduler.
interface alu_sched_if #(
  parameter int CNT_W = 16
) ();
  logic             req0_valid;
  logic             req0_ready;
  logic [2:0]       req0_op;
  logic [7:0]       req0_a;
  logic [7:0]       req0_b;
  logic             req1_valid;
  logic             req1_ready;
  logic [2:0]       req1_op;
  logic [7:0]       req1_a;
  logic [7:0]       req1_b;
  logic             rsp0_valid;
  logic             rsp0_ready;
  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [7:0]       rsp_data;
  logic             rsp_err;
  logic             busy;
  logic [CNT_W-1:0] done_cnt;

  // Requester side: drives operations and response acceptance.
  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_data, rsp_err, busy, done_cnt
  );

  // Scheduler side.
  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp_data, rsp_err, busy, done_cnt
  );
endinterface

// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one 8-bit ALU between two requesters.
// One operation in flight at a time: IDLE (arbitrate/accept) -> EXEC -> RESP.
module alu_sched #(
  parameter int CNT_W = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_sched_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_q;
  logic             prio_q;
  logic             owner_q;
  logic [2:0]       op_q;
  logic [7:0]       a_q;
  logic [7:0]       b_q;
  logic [7:0]       res_q;
  logic             err_q;
  logic             rsp0_valid_q;
  logic             rsp1_valid_q;
  logic             busy_q;
  logic [CNT_W-1:0] done_cnt_q;

  logic             gnt_d;
  logic             accept_d;
  logic             rsp_hs_d;
  logic [7:0]       alu_res_d;
  logic             alu_err_d;

  // Grant: a lone valid wins; on contention the priority pointer decides.
  always_comb begin
    gnt_d = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      gnt_d = prio_q;
    end else if (bus.req1_valid) begin
      gnt_d = 1'b1;
    end
    accept_d = (state_q == IDLE) && (bus.req0_valid || bus.req1_valid);
    rsp_hs_d = (state_q == RESP) && (owner_q ? bus.rsp1_ready : bus.rsp0_ready);
  end

  // Shared ALU on the latched operands; illegal opcodes yield zero with err.
  always_comb begin
    alu_res_d = '0;
    alu_err_d = 1'b0;
    case (op_q)
      3'd0:    alu_res_d = a_q + b_q;
      3'd1:    alu_res_d = a_q - b_q;
      3'd2:    alu_res_d = a_q & b_q;
      3'd3:    alu_res_d = a_q | b_q;
      3'd4:    alu_res_d = ~a_q;
      default: alu_err_d = 1'b1;
    endcase
  end

  // Scheduler FSM with registered response, busy and completion count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      prio_q       <= 1'b0;
      owner_q      <= 1'b0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
      err_q        <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_d) begin
            op_q    <= gnt_d ? bus.req1_op : bus.req0_op;
            a_q     <= gnt_d ? bus.req1_a  : bus.req0_a;
            b_q     <= gnt_d ? bus.req1_b  : bus.req0_b;
            owner_q <= gnt_d;
            prio_q  <= ~gnt_d;
            busy_q  <= 1'b1;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          res_q        <= alu_res_d;
          err_q        <= alu_err_d;
          rsp0_valid_q <= ~owner_q;
          rsp1_valid_q <= owner_q;
          state_q      <= RESP;
        end
        RESP: begin
          if (rsp_hs_d) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_cnt_q   <= done_cnt_q + CNT_W'(1);
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req0_ready = accept_d && !gnt_d;
  assign bus.req1_ready = accept_d && gnt_d;
  assign bus.rsp0_valid = rsp0_valid_q;
  assign bus.rsp1_valid = rsp1_valid_q;
  assign bus.rsp_data   = res_q;
  assign bus.rsp_err    = err_q;
  assign bus.busy       = busy_q;
  assign bus.done_cnt   = done_cnt_q;

endmodule

// File: tb/tb_alu_sched.sv
// Scoreboard bench for alu_sched: expectations queued at accept, checked at response.
module tb_alu_sched;

  localparam int CW = 4;

  typedef struct {
    int         port;
    logic [7:0] d;
    logic       e;
    int         acc;
  } exp_t;

  logic clk;
  logic rst_n;
  alu_sched_if #(.CNT_W(CW)) bus ();

  alu_sched #(.CNT_W(CW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          last_acc = -1;
  exp_t        sb[$];
  int          gq[$];
  logic [CW-1:0] exp_done = '0;
  logic        prev_v[2];
  logic        prev_r[2];
  logic [7:0]  prev_d;
  logic        prev_e;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] alu_model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0:    return {1'b0, 8'(a + b)};
      3'd1:    return {1'b0, 8'(a - b)};
      3'd2:    return {1'b0, a & b};
      3'd3:    return {1'b0, a | b};
      3'd4:    return {1'b0, ~a};
      default: return {1'b1, 8'h00};
    endcase
  endfunction

  // Monitor: push expectations on accept, check hold/latency/data on response.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int p = 0; p < 2; p++) begin
        prev_v[p] = 1'b0;
        prev_r[p] = 1'b1;
      end
    end else begin
      if (bus.req0_ready && bus.req1_ready) chk("dual_ready", 32'(bus.req1_ready), 0);
      if (bus.rsp0_valid && bus.rsp1_valid) chk("dual_rsp", 32'(bus.rsp1_valid), 0);
      for (int p = 0; p < 2; p++) begin
        logic qv, qr, rv, rr;
        logic [2:0] op;
        logic [7:0] a, b;
        logic [8:0] m;
        exp_t it;
        qv = (p == 0) ? bus.req0_valid : bus.req1_valid;
        qr = (p == 0) ? bus.req0_ready : bus.req1_ready;
        op = (p == 0) ? bus.req0_op    : bus.req1_op;
        a  = (p == 0) ? bus.req0_a     : bus.req1_a;
        b  = (p == 0) ? bus.req0_b     : bus.req1_b;
        rv = (p == 0) ? bus.rsp0_valid : bus.rsp1_valid;
        rr = (p == 0) ? bus.rsp0_ready : bus.rsp1_ready;
        if (qv && qr) begin
          m = alu_model(op, a, b);
          it.port = p;
          it.d    = m[7:0];
          it.e    = m[8];
          it.acc  = cyc;
          sb.push_back(it);
          gq.push_back(p);
          if (last_acc >= 0) chk("acc_gap_ge3", 32'(cyc - last_acc >= 3), 1);
          last_acc = cyc;
        end
        if (prev_v[p] && !prev_r[p]) begin
          chk("hold_valid", 32'(rv), 1);
          chk("hold_data", 32'(bus.rsp_data), 32'(prev_d));
          chk("hold_err", 32'(bus.rsp_err), 32'(prev_e));
        end
        if (rv && !prev_v[p]) begin
          if (sb.size() == 0) begin
            chk("rsp_unexpected", 32'(rv), 0);
          end else begin
            chk("rsp_port", p, sb[0].port);
            chk("rsp_latency", cyc - sb[0].acc, 2);
          end
        end
        if (rv && rr && sb.size() > 0) begin
          it = sb.pop_front();
          chk("sb_data", 32'(bus.rsp_data), 32'(it.d));
          chk("sb_err", 32'(bus.rsp_err), 32'(it.e));
          chk("done_cnt", 32'(bus.done_cnt), 32'(exp_done));
          exp_done = exp_done + 1'b1;
        end
        prev_v[p] = rv;
        prev_r[p] = rr;
      end
      prev_d = bus.rsp_data;
      prev_e = bus.rsp_err;
    end
  end

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_rdy0"}, 32'(bus.req0_ready), 0);
    chk({tag, "_rdy1"}, 32'(bus.req1_ready), 0);
    chk({tag, "_rv0"},  32'(bus.rsp0_valid), 0);
    chk({tag, "_rv1"},  32'(bus.rsp1_valid), 0);
    chk({tag, "_data"}, 32'(bus.rsp_data), 0);
    chk({tag, "_err"},  32'(bus.rsp_err), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_cnt"},  32'(bus.done_cnt), 0);
  endtask

  task automatic issue(input int p, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic got;
    @(posedge clk); #1;
    if (p == 0) begin
      bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = (p == 0) ? bus.req0_ready : bus.req1_ready;
    end
    chk("accept", 32'(got), 1);
    @(posedge clk); #1;
    if (p == 0) bus.req0_valid = 1'b0;
    else        bus.req1_valid = 1'b0;
  endtask

  task automatic expect_rsp(input int p, input logic [7:0] d, input logic e);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = (p == 0) ? bus.rsp0_valid : bus.rsp1_valid;
    end
    chk("rsp_seen", 32'(got), 1);
    if (got) begin
      chk("rsp_data", 32'(bus.rsp_data), 32'(d));
      chk("rsp_err", 32'(bus.rsp_err), 32'(e));
      chk("rsp_busy", 32'(bus.busy), 1);
    end
  endtask

  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = !bus.busy && (sb.size() == 0);
    end
    chk("idle_reached", 32'(ok), 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk_reset_outs("rst");
    sb.delete();
    gq.delete();
    exp_done = '0;
    last_acc = -1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    bus.req0_valid = 1'b0; bus.req0_op = '0; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 1'b0; bus.req1_op = '0; bus.req1_a = '0; bus.req1_b = '0;
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    do_reset();

    // single add
    issue(0, 3'd0, 8'hF0, 8'h20);
    expect_rsp(0, 8'h10, 1'b0);
    wait_idle();
    chk("done_after_1", 32'(bus.done_cnt), 1);

    // subtract and NOT
    issue(1, 3'd1, 8'h05, 8'h07);
    expect_rsp(1, 8'hFE, 1'b0);
    wait_idle();
    issue(1, 3'd4, 8'h5A, 8'h33);
    expect_rsp(1, 8'hA5, 1'b0);
    wait_idle();

    // illegal opcode then legal
    issue(0, 3'd6, 8'h12, 8'h34);
    expect_rsp(0, 8'h00, 1'b1);
    wait_idle();
    issue(0, 3'd2, 8'hF0, 8'h3C);
    expect_rsp(0, 8'h30, 1'b0);
    wait_idle();

    // backpressure on port 0 while req1 waits
    bus.rsp0_ready = 1'b0;
    issue(0, 3'd3, 8'h81, 8'h18);
    bus.req1_valid = 1'b1; bus.req1_op = 3'd0; bus.req1_a = 8'h01; bus.req1_b = 8'h02;
    expect_rsp(0, 8'h99, 1'b0);
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", 32'(bus.rsp0_valid), 1);
      chk("bp_data", 32'(bus.rsp_data), 32'h99);
      chk("bp_req1_ready", 32'(bus.req1_ready), 0);
      chk("bp_busy", 32'(bus.busy), 1);
    end
    @(posedge clk); #1 bus.rsp0_ready = 1'b1;
    begin
      logic got;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge clk);
        got = bus.req1_ready;
      end
      chk("bp_req1_granted", 32'(got), 1);
      @(posedge clk); #1 bus.req1_valid = 1'b0;
    end
    expect_rsp(1, 8'h03, 1'b0);
    wait_idle();

    // contention from reset: grants alternate starting at 0; count wraps
    @(posedge clk); #1;
    do_reset();
    bus.req0_valid = 1'b1; bus.req0_op = 3'd0;
    bus.req1_valid = 1'b1; bus.req1_op = 3'd1;
    repeat (60) begin
      bus.req0_a = 8'($urandom); bus.req0_b = 8'($urandom);
      bus.req1_a = 8'($urandom); bus.req1_b = 8'($urandom);
      @(posedge clk); #1;
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    wait_idle();
    chk("cont_grants_ge17", 32'(gq.size() >= 17), 1);
    for (int i = 0; i < 17 && i < gq.size(); i++) chk("cont_grant_order", gq[i], i % 2);
    chk("cont_done_wrapped", 32'(bus.done_cnt), 32'(gq.size() % 16));

    // reset during EXEC discards the operation
    issue(0, 3'd0, 8'h11, 8'h22);
    rst_n = 1'b0;
    #1;
    chk_reset_outs("midop");
    sb.delete();
    gq.delete();
    exp_done = '0;
    last_acc = -1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("midop_cnt", 32'(bus.done_cnt), 0);
    chk("midop_rv0", 32'(bus.rsp0_valid), 0);
    chk("midop_busy", 32'(bus.busy), 0);
    issue(1, 3'd0, 8'h7F, 8'h01);
    expect_rsp(1, 8'h80, 1'b0);
    wait_idle();
    chk("post_reset_cnt", 32'(bus.done_cnt), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/alu_sched.md
# alu_sched

Two-port scheduler that shares one 8-bit ALU datapath (add, subtract, AND, OR, NOT) between two requesters. Each requester presents an opcode and operands on a valid/ready handshake. The block arbitrates round-robin, latches the winning operands, and computes the result. It then returns the result on that requester's response handshake. It sits between the instruction/issue logic and the shared ALU, and owns the ALU instance internally.

## Interface
- `CNT_W`, default 16: width of the completed-operation counter.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `req0_valid` / `req1_valid`  in  1  requester n presents an operation.
- `req0_ready` / `req1_ready`  out  1  operation accepted this cycle when valid & ready.
- `req0_op` / `req1_op`  in  3  opcode encoding:
  - 0 = add, 1 = sub (a−b), 2 = AND, 3 = OR, 4 = NOT a.
  - 5–7 are illegal.
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  8  operands.
- `rsp0_valid` / `rsp1_valid`  out  1  result available for requester n.
- `rsp0_ready` / `rsp1_ready`  in  1  requester n consumes the result.
- `rsp_data`  out  8  result, shared by both response ports; meaningful only while a `rsp*_valid` is high.
- `rsp_err`  out  1  illegal opcode flag for the current response.
- `busy`  out  1  high in any state other than IDLE.
- `done_cnt`  out  CNT_W  count of completed responses; wraps.

## Operation
- FSM states:
  - IDLE → EXEC on accept.
  - EXEC → RESP unconditionally.
  - RESP → IDLE when the owner's `rsp_ready` is 1.
- Arbitration happens in IDLE only. The grant is combinational from the valids and a 1-bit priority pointer `prio`:
  - Only one valid: grant that requester.
  - Both valid: grant the requester equal to `prio`.
  - `req_ready` is high only for the granted requester in IDLE; it is 0 in every other state.
- On accept:
  - Latch op, a and b into operand registers, latch owner id.
  - Set `prio` to the non-granted index (`prio` = ~owner).
  - `prio` is unchanged when nothing is accepted.
- EXEC:
  - The ALU computes from the operand registers.
  - Result and err are registered at the end of EXEC.
- ALU arithmetic, 8 bits, carry/borrow discarded:
  - Add and sub wrap modulo 256.
  - NOT ignores b.
  - Illegal opcode: result 8'h00, `rsp_err` = 1. The ALU output is never X at the port.
- RESP:
  - `rsp<owner>_valid` = 1; the other `rsp_valid` stays 0.
  - `rsp_data` and `rsp_err` hold stable until the handshake completes.
- Handshake completes when owner valid & ready at a clock edge. Then:
  - `done_cnt` increments by 1, wrapping from 2^CNT_W−1 to 0.
  - FSM returns to IDLE.
- A requester may drop valid before it is accepted; nothing is latched.
- Inputs are ignored outside IDLE.
- An asserted `rsp_ready` with no matching `rsp_valid` has no effect.
- Reset, asynchronous and valid mid-operation:
  - FSM goes to IDLE and the in-flight operation is discarded with no response.
  - `prio` = 0.
  - All outputs are 0: ready, `rsp_valid`, `rsp_data`, `rsp_err`, `busy`, `done_cnt`.

## Timing
- Accept edge T: EXEC during cycle T+1; `rsp_valid` high from T+2.
- Minimum occupancy is 3 cycles per operation: accept, EXEC, and RESP with immediate `rsp_ready`.
- The next accept is possible at the edge ending the first IDLE cycle after the response handshake, i.e. at T+3 at the earliest.
- `busy` rises the cycle after accept and falls the cycle after the response handshake.
- Backpressure: RESP holds indefinitely while the owner's `rsp_ready` = 0. The other requester waits with its ready low.
- Fairness: under constant contention, grants alternate 0,1,0,1 starting with 0 after reset.
- No combinational path from `rsp_ready` to `rsp_valid`. `req_ready` depends combinationally on `req_valid` only through the grant logic.

## Test plan
- Reset and single op:
  - Stimulus: release `rst_n`, then req0 op=0, a=8'hF0, b=8'h20.
  - Response: `req0_ready`=1 at accept; `rsp0_valid`=1 two cycles later with `rsp_data`=8'h10, `rsp_err`=0; `done_cnt`=1 after the handshake.
- Subtract and NOT:
  - req1 op=1, a=8'h05, b=8'h07 → `rsp_data`=8'hFE.
  - req1 op=4, a=8'h5A → `rsp_data`=8'hA5.
- Round-robin contention:
  - Stimulus: both valid continuously with distinct ops, `rsp_ready` tied 1.
  - Response: grants alternate 0,1,0,1. Each response appears only on the owner's port. Minimum spacing between accepts is 3 cycles.
- Illegal opcode:
  - Stimulus: req0 op=6, a=8'h12, b=8'h34.
  - Response: `rsp_data`=8'h00, `rsp_err`=1; next legal op returns `rsp_err`=0.
- Backpressure:
  - Stimulus: `rsp0_ready`=0 for 5 cycles while req1 valid.
  - Response: `rsp0_valid` and `rsp_data` held stable; `req1_ready`=0 throughout; req1 is granted after the handshake.
- Reset mid-operation:
  - Stimulus: assert `rst_n`=0 during EXEC.
  - Response: all outputs 0 immediately; no response is ever produced for that op; `done_cnt`=0.
